// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - CPU run control (reset sequencing, halt/timeout) with optional writeback trace FIFO (RUN_MONITOR_TRACE_EN)
module cpu_run_monitor #(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 3,
    parameter int CNT_W       = 16,
    parameter int RST_CYCLES  = 2,
    parameter int HALT_CYCLES = 4,
    parameter int MAX_CYCLES  = 1024,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PC_W-1:0]       pc,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  cpu_rst_n,
    output logic                  running,
    output logic                  done,
    output logic                  halted,
    output logic                  timeout,
    output logic [CNT_W-1:0]      cycle_count,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [CNT_W-1:0]      trace_cycle,
    output logic [REG_ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0]     trace_data,
    output logic                  trace_overflow
);

    localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int STALL_W = $clog2(HALT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_next;
    logic [CNT_W-1:0]   count_next;
    logic [PC_W-1:0]    last_pc;
    logic               first_run;
    logic               hit_halt;
    logic               hit_limit;
    logic               run_clear;

    // A start pulse is honoured only from IDLE or DONE; it also wipes the trace state
    assign run_clear = start && ((state == S_IDLE) || (state == S_DONE));

    // Next-cycle stall count and cycle count, used to decide termination at this edge
    always_comb begin
        count_next = cycle_count + CNT_W'(1);
        if (first_run || (pc != last_pc)) begin
            stall_next = '0;
        end else begin
            stall_next = stall_cnt + STALL_W'(1);
        end
        hit_halt  = (stall_next == STALL_W'(HALT_CYCLES));
        hit_limit = (count_next == CNT_W'(MAX_CYCLES));
    end

    // Run-control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cpu_rst_n   <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            hold_cnt    <= '0;
            stall_cnt   <= '0;
            last_pc     <= '0;
            first_run   <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_HOLD;
                        cpu_rst_n   <= 1'b0;
                        running     <= 1'b0;
                        done        <= 1'b0;
                        halted      <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        hold_cnt    <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                        state     <= S_RUN;
                        cpu_rst_n <= 1'b1;
                        running   <= 1'b1;
                        stall_cnt <= '0;
                        first_run <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    cycle_count <= count_next;
                    last_pc     <= pc;
                    first_run   <= 1'b0;
                    stall_cnt   <= stall_next;
                    if (hit_halt || hit_limit) begin
                        state   <= S_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        halted  <= hit_halt;
                        timeout <= hit_limit;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RUN_MONITOR_TRACE_EN
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int ENT_W = CNT_W + REG_ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W:0]   fill;
    logic [PTR_W:0]   fill_next;
    logic [ENT_W-1:0] entry_in;
    logic [ENT_W-1:0] head_next;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;

    // Push/pop arbitration; head is re-fetched from the post-update read pointer so it stays registered
    always_comb begin
        push      = (state == S_RUN) && wb_en;
        pop       = trace_valid && trace_ready;
        full      = (fill == (PTR_W+1)'(TRACE_DEPTH));
        push_ok   = push && (!full || pop);
        entry_in  = {cycle_count, wb_addr, wb_data};
        rd_next   = rd_ptr + PTR_W'(pop);
        fill_next = fill + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
        // FIFO empty after this pop: the incoming entry becomes the head directly
        if (push_ok && (fill == (PTR_W+1)'(pop))) begin
            head_next = entry_in;
        end else begin
            head_next = mem[rd_next];
        end
    end

    // Trace storage write port
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // Trace pointers, occupancy, sticky overflow and registered head
    always_ff @(posedge clk) begin
        if (!rst || run_clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill           <= '0;
            trace_valid    <= 1'b0;
            trace_overflow <= 1'b0;
            trace_cycle    <= '0;
            trace_addr     <= '0;
            trace_data     <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr      <= rd_next;
            fill        <= fill_next;
            trace_valid <= (fill_next != '0);
            if (push && full && !pop) begin
                trace_overflow <= 1'b1;
            end
            if (fill_next != '0) begin
                {trace_cycle, trace_addr, trace_data} <= head_next;
            end
        end
    end
`else
    logic unused_trace;
    assign unused_trace   = &{1'b0, trace_ready, wb_en, wb_addr, wb_data, run_clear};
    assign trace_valid    = 1'b0;
    assign trace_overflow = 1'b0;
    assign trace_cycle    = '0;
    assign trace_addr     = '0;
    assign trace_data     = '0;
`endif

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

- Synthesizable run-control and trace-capture block that sits beside the pipelined CPU.
- Sequences the CPU's reset, counts executed cycles and detects program halt (PC stalled) or cycle-limit timeout.
- Logs every register-file writeback into a parametrised trace FIFO with a valid/ready drain port.
- Replaces ad-hoc bench-side register dumps with a reusable, width/depth-configurable monitor.

## Interface

Parameters:
- PC_W, 32, program-counter width
- DATA_W, 32, writeback data width
- REG_ADDR_W, 3, register address width (8 registers)
- CNT_W, 16, cycle counter width
- RST_CYCLES, 2, cycles CPU reset is held after start (≥1)
- HALT_CYCLES, 4, consecutive unchanged-PC cycles that declare halt (≥1)
- MAX_CYCLES, 1024, RUN cycle limit (≤2^CNT_W−1)
- TRACE_DEPTH, 8, trace FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin/restart run (single-cycle pulse)
- pc  in  PC_W  CPU fetch PC
- wb_en  in  1  register-file write strobe
- wb_addr  in  REG_ADDR_W  write register index
- wb_data  in  DATA_W  write data
- cpu_rst_n  out  1  active-low reset to CPU
- running  out  1  state is RUN
- done  out  1  state is DONE
- halted  out  1  run ended by PC stall (valid in DONE)
- timeout  out  1  run ended by cycle limit (valid in DONE)
- cycle_count  out  CNT_W  RUN cycles elapsed
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  consumer pops head when trace_valid & trace_ready
- trace_cycle  out  CNT_W  head: cycle_count at capture
- trace_addr  out  REG_ADDR_W  head: register index
- trace_data  out  DATA_W  head: write data
- trace_overflow  out  1  sticky: an entry was dropped

## Operation

- States: IDLE → HOLD → RUN → DONE.
- IDLE:
  - cpu_rst_n=0.
  - start → HOLD; clears cycle_count, halted, timeout, trace_overflow and the FIFO.
- HOLD:
  - cpu_rst_n=0 for exactly RST_CYCLES cycles, then → RUN.
  - start ignored.
- RUN:
  - cpu_rst_n=1; cycle_count increments every cycle.
  - last_pc register compares pc; a stall counter increments on equality and clears on change. The first RUN cycle only loads last_pc.
  - Stall counter reaching HALT_CYCLES → DONE, halted=1.
  - cycle_count reaching MAX_CYCLES → DONE, timeout=1.
  - Both in the same cycle → DONE with both flags set.
  - start ignored.
- DONE:
  - cpu_rst_n=1 (CPU keeps running); cycle_count, flags frozen.
  - start → HOLD (restart, same clears as IDLE).
- Trace capture:
  - Only in RUN. Each cycle with wb_en=1 pushes {cycle_count, wb_addr, wb_data}; cycle_count is the pre-increment value.
  - Push when full and no pop: entry dropped, trace_overflow=1 (sticky until start or reset).
  - Full with simultaneous pop: push accepted, occupancy unchanged.
  - Pop allowed in every state; the FIFO keeps contents in DONE until drained or cleared by start.
  - Pointers wrap modulo TRACE_DEPTH; occupancy counter is log2(TRACE_DEPTH)+1 bits.
- Reset (rst=0 at any edge, including mid-RUN) → IDLE, FIFO empty, all outputs at reset values.

## Timing

- Reset values:
  - cpu_rst_n=0, running=0, done=0, halted=0, timeout=0.
  - cycle_count=0, trace_valid=0, trace_overflow=0, trace_cycle/addr/data=0.
- All outputs registered.
- start at edge N:
  - State is HOLD from N+1; cpu_rst_n rises at N+1+RST_CYCLES.
  - running=1 from that same cycle.
- Push at edge N → trace_valid=1 after edge N (visible in cycle N+1). Head fields stable while trace_valid & !trace_ready.
- Pop at edge N → next entry presented after edge N; no bubble.
- Halt/timeout detected at edge N → done=1 and running=0 after edge N; a wb_en in that same final cycle is still captured.

## Configuration

- RUN_MONITOR_TRACE_EN defined: trace FIFO and trace_* ports are functional as above.
- Not defined:
  - FIFO logic not built.
  - trace_valid, trace_overflow, trace_cycle, trace_addr, trace_data tied to 0; trace_ready ignored.
  - Run control unaffected.

## Test plan

- Reset/hold: rst=0 for 2 cycles, then start pulse. Outputs at reset values during rst; cpu_rst_n=0 for exactly 2 cycles after HOLD entry, then running=1.
- Halt: pc increments 0,4,8,…,0x10, then holds at 0x10 with HALT_CYCLES=4. done=1, halted=1, timeout=0; cycle_count frozen.
- Timeout: MAX_CYCLES=20, pc always changing. done=1, timeout=1 with cycle_count=20; simultaneous halt on cycle 20 sets both flags.
- Trace order and ready:
  - Writes r1=0x5, r2=0xA, r3=0xF in consecutive cycles with trace_ready=0, then trace_ready=1.
  - Entries pop in order with correct cycle stamps; head held stable while stalled.
- Overflow: TRACE_DEPTH=8, 10 writes, trace_ready=0. 8 entries retained, trace_overflow=1. A full-with-pop cycle accepts its push.
- Mid-run reset and restart:
  - rst=0 during RUN → IDLE, FIFO empty.
  - start in DONE clears flags, overflow and FIFO, then reruns.
  - With RUN_MONITOR_TRACE_EN undefined, trace_valid stays 0 throughout.
